// File: rtl/dm_lsu_if.sv
// dm_lsu_if: request/response bundle between the pipeline MEM stage and dm_lsu.
//   Request  : req_valid/req_ready handshake with req_we, req_size, req_signed,
//              req_addr, req_wdata.
//   Response : rsp_valid/rsp_ready handshake with rsp_rdata, rsp_err.
//   master   : the requester (pipeline or testbench).
//   slave    : the load/store unit.
interface dm_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dm_lsu.sv
// dm_lsu: load/store unit with an integrated single-port word-wide data memory.
//   One request is accepted per handshake and answered by exactly one response.
//   Sub-word stores are a read-modify-write (read at accept, write in MERGE).
//   Loads are sign- or zero-extended from the registered word.
//   Misaligned or reserved-size requests answer with rsp_err=1 and leave memory alone.
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      dm_lsu_if.slave request/response bundle
// Parameters:
//   DEPTH_LOG2  log2 of memory depth in 32-bit words (upper address bits alias)
//   ALLOW_B2B   accept a new request in the same cycle a response is consumed
module dm_lsu #(
  parameter int DEPTH_LOG2 = 12,
  parameter bit ALLOW_B2B  = 1'b1
) (
  input  logic    clk,
  input  logic    reset_n,
  dm_lsu_if.slave bus
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] MERGE = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  logic [1:0]            state, state_nxt;
  logic [31:0]           mem [DEPTH];
  logic [31:0]           rd_word;
  logic [31:0]           merged;
  logic [31:0]           load_data;
  logic [7:0]            byte_v;
  logic [15:0]           half_v;

  logic [DEPTH_LOG2-1:0] idx_q;
  logic [1:0]            lane_q;
  logic [1:0]            size_q;
  logic                  we_q;
  logic                  signed_q;
  logic                  err_q;
  logic [15:0]           wdata_q;

  logic                  accept;
  logic                  req_err;
  logic                  req_load;
  logic                  req_word_store;
  logic                  req_sub_store;
  logic [DEPTH_LOG2-1:0] req_idx;
  logic                  unused_addr;

  assign bus.req_ready = (state == IDLE) ||
                         (ALLOW_B2B && (state == RESP) && bus.rsp_ready);
  assign accept        = bus.req_valid && bus.req_ready;

  assign req_idx     = bus.req_addr[DEPTH_LOG2+1:2];
  assign unused_addr = &{1'b0, bus.req_addr[31:DEPTH_LOG2+2]};

  // Reserved size 11 is lumped in with misalignment so the rest of the
  // decode only ever sees byte, half or word.
  assign req_err = (bus.req_size == 2'b11) ||
                   ((bus.req_size == SZ_HALF) && bus.req_addr[0]) ||
                   ((bus.req_size == SZ_WORD) && (bus.req_addr[1:0] != 2'b00));
  assign req_load       = !bus.req_we && !req_err;
  assign req_word_store = bus.req_we && !req_err && (bus.req_size == SZ_WORD);
  assign req_sub_store  = bus.req_we && !req_err && (bus.req_size != SZ_WORD);

  // An accept always wins, so a back-to-back request out of RESP is
  // dispatched exactly as it would be from IDLE.
  always_comb begin
    state_nxt = state;
    if (accept) begin
      state_nxt = req_sub_store ? MERGE : RESP;
    end else begin
      case (state)
        IDLE:    state_nxt = IDLE;
        MERGE:   state_nxt = RESP;
        RESP:    state_nxt = bus.rsp_ready ? IDLE : RESP;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Request fields held for the merge and for building the response.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_q    <= '0;
      lane_q   <= 2'b00;
      size_q   <= 2'b00;
      we_q     <= 1'b0;
      signed_q <= 1'b0;
      err_q    <= 1'b0;
      wdata_q  <= 16'h0000;
    end else if (accept) begin
      idx_q    <= req_idx;
      lane_q   <= bus.req_addr[1:0];
      size_q   <= bus.req_size;
      we_q     <= bus.req_we;
      signed_q <= bus.req_signed;
      err_q    <= req_err;
      wdata_q  <= bus.req_wdata[15:0];
    end
  end

  // The array itself is not reset. Writes are additionally gated by reset_n
  // so a store sitting on the bus during reset, or a merge cut short by
  // reset, never reaches memory.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      if (accept && req_word_store) begin
        mem[req_idx] <= bus.req_wdata;
      end else if (state == MERGE) begin
        mem[idx_q] <= merged;
      end
      if (accept && (req_load || req_sub_store)) begin
        rd_word <= mem[req_idx];
      end
    end
  end

  // Insert the stored byte or half into the old word at its lane.
  always_comb begin
    merged = rd_word;
    if (size_q == SZ_BYTE) begin
      merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
    end else if (lane_q[1]) begin
      merged[31:16] = wdata_q;
    end else begin
      merged[15:0] = wdata_q;
    end
  end

  // Lane select plus extension of the registered load word.
  always_comb begin
    byte_v = rd_word[{lane_q, 3'b000} +: 8];
    half_v = lane_q[1] ? rd_word[31:16] : rd_word[15:0];
    case (size_q)
      SZ_BYTE: load_data = {{24{signed_q & byte_v[7]}}, byte_v};
      SZ_HALF: load_data = {{16{signed_q & half_v[15]}}, half_v};
      default: load_data = rd_word;
    endcase
  end

  // Outputs are pure functions of state and held fields, so they follow
  // reset immediately and stay stable while the consumer stalls.
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_err   = (state == RESP) && err_q;
  assign bus.rsp_rdata = ((state == RESP) && !we_q && !err_q) ? load_data : 32'h0;

endmodule

// File: tb/tb_dm_lsu.sv
// tb_dm_lsu: self-checking bench for dm_lsu. Directed cases from the feature
// list, backpressure with a back-to-back accept, reset during MERGE and RESP,
// then randomized requests against a word-array reference model.
module tb_dm_lsu;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  dm_lsu_if bus();

  dm_lsu #(
    .DEPTH_LOG2(12),
    .ALLOW_B2B (1'b1)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] modelMem [int];
  logic [31:0] got;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Reference model: the memory is an array of words; a request picks a
  // shift and a mask from its size and address and does plain arithmetic.
  function automatic logic [31:0] modelReq(input logic we, input logic [1:0] size, input logic sgn,
                                            input logic [31:0] addr, input logic [31:0] wdata,
                                            output logic err, output int lat);
    int          idx;
    int          shift;
    logic [31:0] mask;
    logic [31:0] word;
    logic [31:0] val;
    idx = int'(addr[13:2]);
    err = (size == 2'b11) || (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00);
    lat = 1;
    if (err) return 32'h0;
    word = modelMem.exists(idx) ? modelMem[idx] : 32'h0;
    if (size == 2'b00) begin
      shift = int'(addr[1:0]) * 8;
      mask  = 32'h0000_00FF;
    end else if (size == 2'b01) begin
      shift = int'(addr[1]) * 16;
      mask  = 32'h0000_FFFF;
    end else begin
      shift = 0;
      mask  = 32'hFFFF_FFFF;
    end
    if (we) begin
      modelMem[idx] = (word & ~(mask << shift)) | ((wdata & mask) << shift);
      if (size != 2'b10) lat = 2;
      return 32'h0;
    end
    val = (word >> shift) & mask;
    if (sgn && size != 2'b10 && val > (mask >> 1)) val = val | ~mask;
    return val;
  endfunction

  task automatic driveReq(input logic we, input logic [1:0] size, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wdata);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_size   = size;
    bus.req_signed = sgn;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
  endtask

  // One complete transaction: accept, measure latency, check the response,
  // stall for 'hold' cycles, then consume it.
  task automatic applyStimulus(input logic we, input logic [1:0] size, input logic sgn,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input int hold, output logic [31:0] rdata);
    logic        expErr;
    int          expLat;
    logic [31:0] expData;
    int          lat;
    expData = modelReq(we, size, sgn, addr, wdata, expErr, expLat);
    @(negedge clk);
    driveReq(we, size, sgn, addr, wdata);
    bus.rsp_ready = 1'b0;
    #1;
    checkOutput("req_ready_idle", {31'b0, bus.req_ready}, 32'd1);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    lat = 0;
    while (lat < 6) begin
      @(negedge clk);
      lat++;
      if (bus.rsp_valid === 1'b1) break;
    end
    checkOutput("latency", lat, expLat);
    checkOutput("rsp_err", {31'b0, bus.rsp_err}, {31'b0, expErr});
    checkOutput("rsp_rdata", bus.rsp_rdata, expData);
    rdata = bus.rsp_rdata;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checkOutput("hold_valid", {31'b0, bus.rsp_valid}, 32'd1);
      checkOutput("hold_rdata", bus.rsp_rdata, expData);
      checkOutput("hold_req_ready", {31'b0, bus.req_ready}, 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
    @(negedge clk);
    checkOutput("rsp_valid_drop", {31'b0, bus.rsp_valid}, 32'd0);
  endtask

  // Load under 3 cycles of backpressure, then a second load accepted in the
  // same cycle the first response is consumed.
  task automatic b2bTest();
    logic        e;
    int          l;
    logic [31:0] exp1;
    logic [31:0] exp2;
    exp1 = modelReq(1'b0, 2'b10, 1'b0, 32'h0000_0000, 32'h0, e, l);
    @(negedge clk);
    driveReq(1'b0, 2'b10, 1'b0, 32'h0000_0000, 32'h0);
    bus.rsp_ready = 1'b0;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    checkOutput("bp_valid", {31'b0, bus.rsp_valid}, 32'd1);
    checkOutput("bp_rdata", bus.rsp_rdata, exp1);
    repeat (3) begin
      @(negedge clk);
      checkOutput("bp_hold_valid", {31'b0, bus.rsp_valid}, 32'd1);
      checkOutput("bp_hold_rdata", bus.rsp_rdata, exp1);
      checkOutput("bp_hold_ready", {31'b0, bus.req_ready}, 32'd0);
    end
    exp2 = modelReq(1'b0, 2'b10, 1'b0, 32'h0000_0004, 32'h0, e, l);
    driveReq(1'b0, 2'b10, 1'b0, 32'h0000_0004, 32'h0);
    bus.rsp_ready = 1'b1;
    #1;
    checkOutput("b2b_req_ready", {31'b0, bus.req_ready}, 32'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    checkOutput("b2b_valid", {31'b0, bus.rsp_valid}, 32'd1);
    checkOutput("b2b_rdata", bus.rsp_rdata, exp2);
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
    @(negedge clk);
    checkOutput("b2b_drop", {31'b0, bus.rsp_valid}, 32'd0);
  endtask

  // Reset during MERGE abandons the write; reset during RESP drops the response.
  task automatic resetTest();
    logic [31:0] d;
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'hCAFE_F00D, 0, d);
    @(negedge clk);
    driveReq(1'b1, 2'b00, 1'b0, 32'h0000_0010, 32'h0000_0055);
    bus.rsp_ready = 1'b0;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    checkOutput("merge_no_valid", {31'b0, bus.rsp_valid}, 32'd0);
    checkOutput("merge_req_ready", {31'b0, bus.req_ready}, 32'd0);
    reset_n = 1'b0;
    #1;
    checkOutput("rst_merge_ready", {31'b0, bus.req_ready}, 32'd1);
    checkOutput("rst_merge_valid", {31'b0, bus.rsp_valid}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0, 0, d);
    checkOutput("rst_merge_word", d, 32'hCAFE_F00D);
    @(negedge clk);
    driveReq(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    checkOutput("resp_before_rst", {31'b0, bus.rsp_valid}, 32'd1);
    reset_n = 1'b0;
    #1;
    checkOutput("rst_resp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    checkOutput("rst_resp_rdata", bus.rsp_rdata, 32'h0);
    checkOutput("rst_resp_err", {31'b0, bus.rsp_err}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_resp_gone", {31'b0, bus.rsp_valid}, 32'd0);
  endtask

  initial begin
    reset_n        = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_size   = 2'b00;
    bus.req_signed = 1'b0;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    bus.rsp_ready  = 1'b0;
    #1;
    checkOutput("reset_valid", {31'b0, bus.rsp_valid}, 32'd0);
    checkOutput("reset_err", {31'b0, bus.rsp_err}, 32'd0);
    checkOutput("reset_rdata", bus.rsp_rdata, 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("reset_ready", {31'b0, bus.req_ready}, 32'd1);

    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 2'b10, 1'b0, i * 4, $urandom, 0, got);
    end

    applyStimulus(1'b1, 2'b10, 1'b0, 32'h000, 32'hDEAD_BEEF, 0, got);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h000, 32'h0, 0, got);
    checkOutput("plan_word_load", got, 32'hDEAD_BEEF);

    applyStimulus(1'b1, 2'b10, 1'b0, 32'h000, 32'h1122_3344, 0, got);
    applyStimulus(1'b1, 2'b00, 1'b0, 32'h002, 32'h0000_00AA, 0, got);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h000, 32'h0, 0, got);
    checkOutput("plan_byte_merge", got, 32'h11AA_3344);
    applyStimulus(1'b0, 2'b00, 1'b1, 32'h002, 32'h0, 0, got);
    checkOutput("plan_byte_signed", got, 32'hFFFF_FFAA);
    applyStimulus(1'b0, 2'b00, 1'b0, 32'h002, 32'h0, 0, got);
    checkOutput("plan_byte_unsigned", got, 32'h0000_00AA);

    applyStimulus(1'b1, 2'b10, 1'b0, 32'h004, 32'h0, 0, got);
    applyStimulus(1'b1, 2'b01, 1'b0, 32'h006, 32'h0000_8001, 1, got);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h004, 32'h0, 0, got);
    checkOutput("plan_half_merge", got, 32'h8001_0000);
    applyStimulus(1'b0, 2'b01, 1'b1, 32'h006, 32'h0, 0, got);
    checkOutput("plan_half_signed", got, 32'hFFFF_8001);
    applyStimulus(1'b0, 2'b01, 1'b0, 32'h006, 32'h0, 0, got);
    checkOutput("plan_half_unsigned", got, 32'h0000_8001);

    applyStimulus(1'b0, 2'b01, 1'b0, 32'h001, 32'h0, 0, got);
    checkOutput("plan_err_half", got, 32'h0);
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h00A, 32'h1234_5678, 0, got);
    applyStimulus(1'b1, 2'b11, 1'b0, 32'h008, 32'h8765_4321, 0, got);
    applyStimulus(1'b0, 2'b11, 1'b0, 32'h008, 32'h0, 0, got);
    checkOutput("plan_err_size", got, 32'h0);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h008, 32'h0, 0, got);

    b2bTest();
    resetTest();

    for (int n = 0; n < 200; n++) begin
      logic [31:0] a;
      a = ($urandom & 32'hFFFF_C000) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    a, $urandom, $urandom_range(0, 2), got);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
